// File: rtl/router_pkg.sv
// Purpose: shared widths, depths and the stored-word type for the router output FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    localparam int DATA_W         = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int PTR_W          = 5;
    localparam int ADDR_W         = PTR_W - 1;
    localparam int PKT_CNT_W      = 7;
    localparam int TIMEOUT_CYCLES = 30;
    localparam int TMO_W          = 5;

    // One FIFO entry: header flag on top, payload byte below.
    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] dat;
    } fifo_word_t;

    // Header length field plus one for the parity byte.
    function automatic logic [PKT_CNT_W-1:0] pkt_load(input logic [DATA_W-1:0] hdr_byte);
        return {1'b0, hdr_byte[DATA_W-1:2]} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Purpose: byte-wide write/read bus between router stages and one output FIFO.
// Latency: n/a (wiring only).
// Backpressure: writer watches full, reader watches empty/vld_out.
interface router_out_fifo_if;
    import router_pkg::*;

    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              vld_out;
    logic              full;
    logic              empty;
    logic              pkt_end;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, vld_out, full, empty, pkt_end
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, vld_out, full, empty, pkt_end
    );

endinterface

// File: rtl/router_fifo_tmo.sv
// Purpose: counts consecutive cycles of valid data that nobody reads and flags a stall.
// Latency: hit is combinational during the TIMEOUT_CYCLES-th stalled cycle.
// Backpressure: none; any read, flush or reset restarts the count.
module router_fifo_tmo
    import router_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic vld,
    input  logic read_enb,
    output logic hit
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] cnt;
    logic             stall;

    assign stall = vld && !read_enb;
    assign hit   = stall && (cnt == TMO_LAST);

    // Stall counter: restarts whenever the run of unread valid cycles is broken.
    always_ff @(posedge clock) begin
        if (reset || clear || hit || !stall) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/router_out_fifo.sv
// Purpose: 16x9 router output FIFO with packet-end detection; ROUTER_FIFO_TIMEOUT_EN adds a stall self-flush.
// Latency: data_out registered, valid one cycle after read_enb sampled with empty=0.
// Backpressure: writes dropped while full, reads ignored while empty (pre-edge occupancy).
module router_out_fifo
    import router_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic soft_reset,
`ifdef ROUTER_FIFO_TIMEOUT_EN
    output logic soft_reset_out,
`endif
    router_out_fifo_if.slave bus
);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    fifo_word_t           mem [FIFO_DEPTH];
    fifo_word_t           wr_word;
    fifo_word_t           rd_word;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic [DATA_W-1:0]    data_q;
    logic                 pkt_end_q;
    logic                 full_w;
    logic                 empty_w;
    logic                 do_wr;
    logic                 do_rd;
    logic                 flush;
    logic                 tmo_hit;

`ifdef ROUTER_FIFO_TIMEOUT_EN
    router_fifo_tmo u_tmo (
        .clock    (clock),
        .reset    (reset),
        .clear    (soft_reset),
        .vld      (!empty_w),
        .read_enb (bus.read_enb),
        .hit      (tmo_hit)
    );
    assign soft_reset_out = tmo_hit;
`else
    assign tmo_hit = 1'b0;
`endif

    // A stall timeout flushes exactly like an external soft reset.
    assign flush = soft_reset || tmo_hit;

    assign full_w  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign empty_w = (wr_ptr == rd_ptr);
    assign do_wr   = bus.write_enb && !full_w;
    assign do_rd   = bus.read_enb && !empty_w;

    assign wr_word.hdr = bus.lfd_state;
    assign wr_word.dat = bus.data_in;
    assign rd_word     = mem[rd_ptr[ADDR_W-1:0]];

    assign bus.data_out = data_q;
    assign bus.pkt_end  = pkt_end_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.vld_out  = !empty_w;

    // Pointers: flush beats any read/write in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage: not cleared on reset, only gated so a flushed write never lands.
    always_ff @(posedge clock) begin
        if (do_wr && !reset && !flush) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
        end
    end

    // Read data and packet tracking; a header always reloads, abandoning any partial packet.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            data_q    <= '0;
            pkt_cnt   <= '0;
            pkt_end_q <= 1'b0;
        end else begin
            pkt_end_q <= 1'b0;
            if (do_rd) begin
                data_q <= rd_word.dat;
                if (rd_word.hdr) begin
                    pkt_cnt <= pkt_load(rd_word.dat);
                end else if (pkt_cnt != '0) begin
                    pkt_cnt   <= pkt_cnt - PKT_CNT_W'(1);
                    pkt_end_q <= (pkt_cnt == PKT_CNT_W'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_router_out_fifo.sv
// Purpose: directed self-checking bench for router_out_fifo.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: exercised via full/empty corner vectors.
module tb_router_out_fifo;
    import router_pkg::*;

    logic clock;
    logic reset;
    logic soft_reset;
`ifdef ROUTER_FIFO_TIMEOUT_EN
    logic soft_reset_out;
`endif

    router_out_fifo_if bus ();

    router_out_fifo dut (
        .clock          (clock),
        .reset          (reset),
        .soft_reset     (soft_reset),
`ifdef ROUTER_FIFO_TIMEOUT_EN
        .soft_reset_out (soft_reset_out),
`endif
        .bus            (bus.slave)
    );

    int checks;
    int failures;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        soft_reset    = 1'b0;
    endtask

    task automatic write_byte(input logic lfd, input logic [7:0] d);
        bus.write_enb = 1'b1;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        tick();
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", bus.full); end
        checks++; if (bus.vld_out !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", bus.vld_out); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", bus.data_out); end
        checks++; if (bus.pkt_end !== 1'b0) begin failures++; $display("FAIL reset_pkt_end got=%b want=0", bus.pkt_end); end
    endtask

    task automatic test_packet();
        logic [7:0] exp [5];
        exp[0] = 8'h0C; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3; exp[4] = 8'h5F;
        write_byte(1'b1, exp[0]);
        checks++; if (bus.vld_out !== 1'b1) begin failures++; $display("FAIL pkt_vld_first got=%b want=1", bus.vld_out); end
        for (int i = 1; i < 5; i++) write_byte(1'b0, exp[i]);
        bus.read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.data_out !== exp[i]) begin failures++; $display("FAIL pkt_data[%0d] got=%h want=%h", i, bus.data_out, exp[i]); end
            checks++; if (bus.pkt_end !== (i == 4)) begin failures++; $display("FAIL pkt_end[%0d] got=%b want=%b", i, bus.pkt_end, (i == 4)); end
        end
        bus.read_enb = 1'b0;
        tick();
        checks++; if (bus.pkt_end !== 1'b0) begin failures++; $display("FAIL pkt_end_drop got=%b want=0", bus.pkt_end); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL pkt_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_full_drop();
        logic [7:0] last;
        for (int i = 0; i < 16; i++) write_byte(1'b0, 8'h10 + 8'(i));
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL full_after16 got=%b want=1", bus.full); end
        write_byte(1'b0, 8'hFF);
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL full_after17 got=%b want=1", bus.full); end
        bus.read_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (bus.data_out !== 8'h10 + 8'(i)) begin failures++; $display("FAIL full_rd[%0d] got=%h want=%h", i, bus.data_out, 8'h10 + 8'(i)); end
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b want=1", bus.empty); end
        // Read while empty: data_out holds, still empty.
        last = bus.data_out;
        tick();
        bus.read_enb = 1'b0;
        checks++; if (bus.data_out !== 8'h1F || last !== 8'h1F) begin failures++; $display("FAIL empty_rd_hold got=%h want=1f", bus.data_out); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL empty_rd_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_full_rw();
        int n;
        for (int i = 0; i < 16; i++) write_byte(1'b0, 8'h40 + 8'(i));
        bus.write_enb = 1'b1;
        bus.data_in   = 8'hEE;
        bus.read_enb  = 1'b1;
        tick();
        bus.write_enb = 1'b0;
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL full_rw_full got=%b want=0", bus.full); end
        checks++; if (bus.data_out !== 8'h40) begin failures++; $display("FAIL full_rw_data got=%h want=40", bus.data_out); end
        n = 0;
        while (bus.empty !== 1'b1 && n < 20) begin
            tick();
            n++;
            checks++; if (bus.data_out !== 8'h40 + 8'(n)) begin failures++; $display("FAIL full_rw_rd[%0d] got=%h want=%h", n, bus.data_out, 8'h40 + 8'(n)); end
        end
        bus.read_enb = 1'b0;
        checks++; if (n !== 15) begin failures++; $display("FAIL full_rw_occupancy got=%0d want=15", n); end
    endtask

    task automatic test_empty_rw();
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h33;
        bus.read_enb  = 1'b1;
        tick();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        checks++; if (bus.data_out !== 8'h4F) begin failures++; $display("FAIL empty_rw_data got=%h want=4f", bus.data_out); end
        checks++; if (bus.vld_out !== 1'b1) begin failures++; $display("FAIL empty_rw_vld got=%b want=1", bus.vld_out); end
        bus.read_enb = 1'b1;
        tick();
        bus.read_enb = 1'b0;
        checks++; if (bus.data_out !== 8'h33) begin failures++; $display("FAIL empty_rw_rd got=%h want=33", bus.data_out); end
    endtask

    task automatic test_soft_reset();
        write_byte(1'b0, 8'h11);
        write_byte(1'b0, 8'h22);
        write_byte(1'b0, 8'h77);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL srst_empty got=%b want=1", bus.empty); end
        checks++; if (bus.vld_out !== 1'b0) begin failures++; $display("FAIL srst_vld got=%b want=0", bus.vld_out); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL srst_data got=%h want=00", bus.data_out); end
        bus.read_enb = 1'b1;
        tick();
        bus.read_enb = 1'b0;
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL srst_rd_data got=%h want=00", bus.data_out); end
        // Write coincident with soft_reset is discarded.
        soft_reset    = 1'b1;
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h55;
        tick();
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL srst_wr_drop got=%b want=1", bus.empty); end
    endtask

    task automatic test_pkt_corner();
        logic [7:0] dat [7];
        logic       pe  [7];
        // Zero-length header + parity, then a truncated packet followed by a new one.
        write_byte(1'b1, 8'h00);
        write_byte(1'b0, 8'h99);
        write_byte(1'b1, 8'h08);
        write_byte(1'b0, 8'h01);
        write_byte(1'b1, 8'h04);
        write_byte(1'b0, 8'h02);
        write_byte(1'b0, 8'h03);
        dat[0] = 8'h00; pe[0] = 1'b0;
        dat[1] = 8'h99; pe[1] = 1'b1;
        dat[2] = 8'h08; pe[2] = 1'b0;
        dat[3] = 8'h01; pe[3] = 1'b0;
        dat[4] = 8'h04; pe[4] = 1'b0;
        dat[5] = 8'h02; pe[5] = 1'b0;
        dat[6] = 8'h03; pe[6] = 1'b1;
        bus.read_enb = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (bus.data_out !== dat[i]) begin failures++; $display("FAIL corner_data[%0d] got=%h want=%h", i, bus.data_out, dat[i]); end
            checks++; if (bus.pkt_end !== pe[i]) begin failures++; $display("FAIL corner_pe[%0d] got=%b want=%b", i, bus.pkt_end, pe[i]); end
        end
        bus.read_enb = 1'b0;
        tick();
    endtask

`ifdef ROUTER_FIFO_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        int first;
        pulses = 0;
        first  = 0;
        write_byte(1'b0, 8'h5A);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (soft_reset_out === 1'b1) begin
                pulses++;
                if (first == 0) first = cyc;
            end
            tick();
            if (cyc == 30) begin
                checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL tmo_empty got=%b want=1", bus.empty); end
            end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL tmo_pulses got=%0d want=1", pulses); end
        checks++; if (first !== 30) begin failures++; $display("FAIL tmo_cycle got=%0d want=30", first); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_packet();
        test_full_drop();
        test_full_rw();
        test_empty_rw();
        test_soft_reset();
        test_pkt_corner();
`ifdef ROUTER_FIFO_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
